// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// Package uart_pkg: FSM state type, data width, default sizing and the
// round-robin pointer increment helper.
package uart_pkg;

  localparam int          DATA_W            = 8;
  localparam int          DEF_N_REQ         = 4;
  localparam logic [15:0] DEF_TIMEOUT_TICKS = 16'd200;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    ACK
  } state_t;

  // Next round-robin pointer after granting idx, wrapping at n-1 back to 0
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return 3'd0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester and transmitter-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
// Optional watchdog output timeout_err exists only with UART_TX_ARB_TIMEOUT_EN.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ
) ();

  logic [N_REQ-1:0]        req;
  logic [DATA_W*N_REQ-1:0] dato_req;
  logic [N_REQ-1:0]        ack;
  logic                    tick;
  logic                    tx_start;
  logic [DATA_W-1:0]       dato_tx;
  logic                    tx_done_tick;
  logic                    busy;
  logic [2:0]              grant_id;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic                    timeout_err;
`endif

  modport slave (
    input  req, dato_req, tick, tx_done_tick,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output timeout_err,
`endif
    output ack, tx_start, dato_tx, busy, grant_id
  );

  modport master (
    output req, dato_req, tick, tx_done_tick,
`ifdef UART_TX_ARB_TIMEOUT_EN
    input  timeout_err,
`endif
    input  ack, tx_start, dato_tx, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping
// from N_REQ-1 to 0, and returns the first requester found.
module uart_rr_pick import uart_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       rr_ptr,
  output logic [2:0]       idx,
  output logic             valid
);

  // First set request at or after rr_ptr wins; later hits are ignored
  always_comb begin
    int c;
    idx   = 3'd0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N_REQ) begin
        c = c - N_REQ;
      end
      if (!valid && (1'(req >> c) == 1'b1)) begin
        valid = 1'b1;
        idx   = 3'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Sequence per frame: IDLE -> LOAD -> START -> WAIT_DONE -> ACK -> IDLE.
// Optional watchdog selected by macro UART_TX_ARB_TIMEOUT_EN: WAIT_DONE gives
// up after TIMEOUT_TICKS baud ticks and flags timeout_err with the ack.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int          N_REQ         = DEF_N_REQ,
  parameter logic [15:0] TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input logic              clock,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_TICKS == 16'd0) begin : g_cfg_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_TICKS nonzero");
  end

  state_t            state;
  state_t            state_nx;
  logic [2:0]        rr_ptr;
  logic [2:0]        pend_idx;
  logic [2:0]        grant_q;
  logic [2:0]        pick_idx;
  logic              pick_valid;
  logic [DATA_W-1:0] dato_q;
  logic [DATA_W-1:0] sel_byte;
  logic              done_prev;
  logic              done_rise;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // A done level already high when WAIT_DONE is entered is not a rise
  assign done_rise = bus.tx_done_tick & ~done_prev;
  assign sel_byte  = DATA_W'(bus.dato_req >> (DATA_W * int'(pend_idx)));

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] tick_cnt;
  logic        timeout_hit;
  logic        timed_out;

  assign timeout_hit = (state == WAIT_DONE) && bus.tick && !done_rise &&
                       (tick_cnt == TIMEOUT_TICKS - 16'd1);

  // Count baud ticks while waiting; remember whether ACK was reached by timeout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= 16'd0;
      timed_out <= 1'b0;
    end else begin
      if (state != WAIT_DONE) begin
        tick_cnt <= 16'd0;
      end else if (bus.tick) begin
        tick_cnt <= tick_cnt + 16'd1;
      end
      timed_out <= timeout_hit;
    end
  end

  assign bus.timeout_err = (state == ACK) && timed_out;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (pick_valid) state_nx = LOAD;
      LOAD:      state_nx = START;
      START:     if (bus.tick) state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (done_rise) begin
          state_nx = ACK;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nx = ACK;
        end
`endif
      end
      ACK:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Winner captured in IDLE, byte/grant latched and pointer advanced in LOAD
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= 3'd0;
      pend_idx  <= 3'd0;
      grant_q   <= 3'd0;
      dato_q    <= '0;
      done_prev <= 1'b0;
    end else begin
      done_prev <= bus.tx_done_tick;
      if (state == IDLE && pick_valid) begin
        pend_idx <= pick_idx;
      end
      if (state == LOAD) begin
        dato_q  <= sel_byte;
        grant_q <= pend_idx;
        rr_ptr  <= rr_next(pend_idx, N_REQ);
      end
    end
  end

  assign bus.tx_start = (state == START);
  assign bus.busy     = (state != IDLE);
  assign bus.ack      = (state == ACK) ? (ACK_ONE << grant_q) : '0;
  assign bus.dato_tx  = dato_q;
  assign bus.grant_id = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 16'd200, giving the baud ticks allowed per frame (used only under REQ-031).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; these ports are fixed as below.
REQ-004 The block SHALL have port clock, input, 1, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ, per-requester transmit request (level).
REQ-007 The block SHALL have port dato_req, input, 8*N_REQ, byte of requester i on bits [8i+7:8i].
REQ-008 The block SHALL have port ack, output, N_REQ, one-cycle pulse when the granted requester's byte has been sent.
REQ-009 The block SHALL have port tick, input, 1, baud-rate tick from the baud generator.
REQ-010 The block SHALL have port tx_start, output, 1, start strobe to the UART transmitter.
REQ-011 The block SHALL have port dato_tx, output, 8, byte presented to the transmitter data input.
REQ-012 The block SHALL have port tx_done_tick, input, 1, end-of-frame indication from the transmitter.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port grant_id, output, 3, index of the current/last granted requester.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, WAIT_DONE and ACK.
REQ-016 IDLE: req sampled each cycle; if any bit is set, go to LOAD next cycle; otherwise stay.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and wraps N_REQ-1 -> 0; the first set req bit wins.
REQ-018 On a grant to i, rr_ptr SHALL become (i+1) mod N_REQ, so i has lowest priority next round.
REQ-019 LOAD: latch dato_req[i] into dato_tx and i into grant_id, then go to START; dato_tx stays stable until the next LOAD.
REQ-020 START: tx_start SHALL be held high until a cycle with tick=1; in that cycle tx_start=1, and next cycle tx_start=0 and state is WAIT_DONE.
REQ-021 WAIT_DONE: go to ACK on the first cycle where tx_done_tick rises (0 in the previous cycle, 1 now); a level already high on entry SHALL NOT count.
REQ-022 ACK: ack[grant_id]=1 for exactly one cycle, all other ack bits 0, then return to IDLE.
REQ-023 req is sampled only in IDLE; a req that drops after grant does not abort the frame, and ack is still pulsed.
REQ-024 A requester that holds req through its ack SHALL be eligible only per the round-robin order in the next IDLE cycle.
REQ-025 Minimum spacing SHALL be one IDLE cycle between ack and the next LOAD.

Reset
REQ-026 On reset_n=0, asynchronously: state=IDLE, tx_start=0, ack=0, busy=0, dato_tx=8'h00, grant_id=0, rr_ptr=0, edge register=0.
REQ-027 Reset mid-frame SHALL drop the frame without an ack; after release the block arbitrates afresh from rr_ptr=0.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN SHALL select the watchdog feature.
REQ-029 Without the macro: no timeout logic is built, no timeout port exists, and WAIT_DONE waits indefinitely.
REQ-030 With the macro: an output port timeout_err, 1 bit, reset 0, SHALL be added.
REQ-031 With the macro: WAIT_DONE counts tick pulses; at TIMEOUT_TICKS without a tx_done_tick rise, the block goes to ACK, pulses ack and sets timeout_err=1 for that same cycle only.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state typedef, DATA_W=8, and the default N_REQ and TIMEOUT_TICKS constants.
REQ-033 Round-robin selection (req, rr_ptr -> winner index and valid) SHALL be sub-module uart_rr_pick, combinational; rr_ptr is stored in the parent.

Verification
REQ-034 Single request: req=4'b0001, dato_req[7:0]=8'h25 -> dato_tx=8'h25; tx_start high until tick; one ack[0] pulse after the tx_done_tick rise.
REQ-035 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each ack is one cycle.
REQ-036 Wrap-around: rr_ptr=3 after grants to 0,1,2; then req=4'b1001 -> grant 3, then grant 0.
REQ-037 Stale done: tx_done_tick held 1 on entry to WAIT_DONE -> no ack until it falls and rises again.
REQ-038 Reset mid-frame: reset_n=0 in WAIT_DONE -> tx_start=0, ack=0, busy=0 immediately; no ack after release.
REQ-039 Timeout with UART_TX_ARB_TIMEOUT_EN and TIMEOUT_TICKS=5, tx_done_tick tied 0 -> after 5 ticks, ack and timeout_err both 1 for one cycle.
